// File: rtl/dmem_map_pkg.sv
// Shared data-memory map for the PS2 key mailbox.
// The processor software uses the same constants to poll the ring:
//   RING_BASE  : word address of ring slot 0
//   RING_DEPTH : number of ring slots (power of two)
//   HEAD_ADDR  : word address holding the ring head index
// Also holds the encoding of the key-writer FSM states.
package dmem_map_pkg;

    localparam logic [11:0] RING_BASE  = 12'hF00;
    localparam int unsigned RING_DEPTH = 16;
    localparam logic [11:0] HEAD_ADDR  = 12'hEFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_DATA = 2'd1,
        WR_HEAD = 2'd2
    } wr_state_t;

endpackage

// File: rtl/key_event_fifo.sv
// Small synchronous FIFO for PS2 key events.
// Ports:
//   clock, resetn : system clock, asynchronous active-low reset
//   push, din     : write request and data
//   pop           : read request (ignored when empty)
//   dout          : oldest entry (valid when !empty)
//   full, empty   : occupancy flags
// A push while full is accepted when a pop happens in the same cycle.
module key_event_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = store[rd_ptr];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clock) begin
        if (do_push) begin
            store[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/dmem_portb_arbiter.sv
// Port-B arbiter for dmem2: VGA reads versus PS2 key mailbox writes.
// Ports:
//   clock, resetn            : system clock, asynchronous active-low reset
//   vga_req/addr/gnt         : VGA read request, held until granted
//   vga_rvalid/rdata         : read data, valid the cycle after a grant
//   key_valid/data           : one-cycle scancode pulse from PS2
//   key_overflow             : sticky "key dropped" flag
//   clear_overflow           : clears key_overflow (a new drop wins)
//   mem_addr/wdata/wren/q    : dmem2 port B
// VGA has priority. Each key becomes a ring-slot data write followed by a
// head-index write. A starvation counter takes the port from the VGA for
// one cycle after STARVE_LIMIT consecutive blocked writer cycles.
module dmem_portb_arbiter #(
    parameter int unsigned         ADDR_W       = 12,
    parameter int unsigned         DATA_W       = 32,
    parameter logic [ADDR_W-1:0]   RING_BASE    = dmem_map_pkg::RING_BASE,
    parameter int unsigned         RING_DEPTH   = dmem_map_pkg::RING_DEPTH,
    parameter logic [ADDR_W-1:0]   HEAD_ADDR    = dmem_map_pkg::HEAD_ADDR,
    parameter int unsigned         FIFO_DEPTH   = 4,
    parameter int unsigned         STARVE_LIMIT = 64
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              key_valid,
    input  logic [7:0]        key_data,
    output logic              key_overflow,
    input  logic              clear_overflow,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    import dmem_map_pkg::wr_state_t;
    import dmem_map_pkg::IDLE;
    import dmem_map_pkg::WR_DATA;
    import dmem_map_pkg::WR_HEAD;

    localparam int unsigned HEAD_W   = $clog2(RING_DEPTH);
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    wr_state_t           state;
    wr_state_t           state_nxt;
    logic [HEAD_W-1:0]   head;
    logic [HEAD_W-1:0]   head_inc;
    logic [STARVE_W-1:0] starve_cnt;
    logic                busy;
    logic                force_slot;
    logic                own_w;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [7:0]          fifo_dout;
    logic                ovf_set;

    // Ring size is a power of two, so the increment wraps on its own.
    assign head_inc   = head + HEAD_W'(1);
    assign busy       = (state != IDLE);
    assign force_slot = (starve_cnt == STARVE_W'(STARVE_LIMIT)) && busy;

    // resetn gates the combinational outputs so they read 0 during reset.
    assign vga_gnt    = vga_req && !force_slot && resetn;
    assign own_w      = !vga_gnt && busy;
    assign vga_rdata  = resetn ? mem_q : '0;

    assign fifo_pop   = own_w && (state == WR_HEAD);
    assign fifo_push  = key_valid && (!fifo_full || fifo_pop);
    assign ovf_set    = key_valid && !fifo_push;

    key_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock  (clock),
        .resetn (resetn),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .din    (key_data),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Writer FSM state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Writer FSM next state
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (!fifo_empty) state_nxt = WR_DATA;
            WR_DATA: if (own_w)       state_nxt = WR_HEAD;
            WR_HEAD: if (own_w)       state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // Port B drive: VGA read, writer data/head write, or idle zeros
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wren  = 1'b0;
        if (vga_gnt) begin
            mem_addr = vga_addr;
        end else if (own_w) begin
            mem_wren = 1'b1;
            if (state == WR_DATA) begin
                mem_addr  = RING_BASE + ADDR_W'(head);
                mem_wdata = DATA_W'(fifo_dout);
            end else begin
                mem_addr  = HEAD_ADDR;
                mem_wdata = DATA_W'(head_inc);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            head         <= '0;
            starve_cnt   <= '0;
            vga_rvalid   <= 1'b0;
            key_overflow <= 1'b0;
        end else begin
            vga_rvalid <= vga_gnt;

            if (fifo_pop) begin
                head <= head_inc;
            end

            if (own_w) begin
                starve_cnt <= '0;
            end else if (busy && vga_gnt && (starve_cnt != STARVE_W'(STARVE_LIMIT))) begin
                starve_cnt <= starve_cnt + STARVE_W'(1);
            end

            if (ovf_set) begin
                key_overflow <= 1'b1;
            end else if (clear_overflow) begin
                key_overflow <= 1'b0;
            end
        end
    end

endmodule
